// File: rtl/snake_score_display.sv
// snake_score_display: binary score to BCD via double-dabble,
// shown on a multiplexed, active-low 3-digit seven-segment display.
module snake_score_display #(
    parameter int REFRESH_BITS  = 17,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] Score,
    input  logic       Score_Valid,
    output logic       Busy,
    output logic [7:0] An,
    output logic [7:0] Seg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t state_q, state_nx;

    logic [7:0]  shift_q, shift_nx;
    logic [11:0] bcd_q, bcd_nx;
    logic [11:0] bcd_adj;
    logic [3:0]  bit_q, bit_nx;
    logic [7:0]  pend_q, pend_nx;
    logic        pend_v_q, pend_v_nx;

    logic [3:0]  hun_q, hun_nx;
    logic [3:0]  ten_q, ten_nx;
    logic [3:0]  one_q, one_nx;

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              idx;

    logic [7:0] an_nx, seg_nx;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'd0:    s = 8'b00000011;
            4'd1:    s = 8'b10011111;
            4'd2:    s = 8'b00100101;
            4'd3:    s = 8'b00001101;
            4'd4:    s = 8'b10011001;
            4'd5:    s = 8'b01001001;
            4'd6:    s = 8'b01000001;
            4'd7:    s = 8'b00011111;
            4'd8:    s = 8'b00000001;
            4'd9:    s = 8'b00001001;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign bcd_adj = {dabble(bcd_q[11:8]),
                      dabble(bcd_q[7:4]),
                      dabble(bcd_q[3:0])};

    // Next-state logic for the conversion FSM and pending request
    always_comb begin
        state_nx  = state_q;
        shift_nx  = shift_q;
        bcd_nx    = bcd_q;
        bit_nx    = bit_q;
        pend_nx   = pend_q;
        pend_v_nx = pend_v_q;
        hun_nx    = hun_q;
        ten_nx    = ten_q;
        one_nx    = one_q;
        unique case (state_q)
            IDLE: begin
                if (Score_Valid) begin
                    shift_nx = Score;
                    bcd_nx   = 12'd0;
                    bit_nx   = 4'd0;
                    state_nx = CONVERT;
                end
            end
            CONVERT: begin
                bcd_nx   = {bcd_adj[10:0], shift_q[7]};
                shift_nx = {shift_q[6:0], 1'b0};
                bit_nx   = bit_q + 4'd1;
                if (bit_q == 4'd7) begin
                    state_nx = COMMIT;
                end
                if (Score_Valid) begin
                    pend_nx   = Score;
                    pend_v_nx = 1'b1;
                end
            end
            COMMIT: begin
                hun_nx = bcd_q[11:8];
                ten_nx = bcd_q[7:4];
                one_nx = bcd_q[3:0];
                if (Score_Valid || pend_v_q) begin
                    // a request arriving now is newer than the stored one
                    shift_nx  = Score_Valid ? Score : pend_q;
                    bcd_nx    = 12'd0;
                    bit_nx    = 4'd0;
                    pend_v_nx = 1'b0;
                    state_nx  = CONVERT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Conversion FSM, datapath and displayed-digit registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            shift_q  <= 8'd0;
            bcd_q    <= 12'd0;
            bit_q    <= 4'd0;
            pend_q   <= 8'd0;
            pend_v_q <= 1'b0;
            hun_q    <= 4'd0;
            ten_q    <= 4'd0;
            one_q    <= 4'd0;
        end else begin
            state_q  <= state_nx;
            shift_q  <= shift_nx;
            bcd_q    <= bcd_nx;
            bit_q    <= bit_nx;
            pend_q   <= pend_nx;
            pend_v_q <= pend_v_nx;
            hun_q    <= hun_nx;
            ten_q    <= ten_nx;
            one_q    <= one_nx;
        end
    end

    assign Busy = (state_q != IDLE);

    // Free-running refresh counter; top two bits select the digit
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    assign idx = refresh_q[REFRESH_BITS-1 -: 2];

    // Digit mux with leading-zero blanking
    always_comb begin
        an_nx  = 8'hFF;
        seg_nx = 8'hFF;
        unique case (idx)
            2'd0: begin
                an_nx  = 8'b11111110;
                seg_nx = seg_of(one_q);
            end
            2'd1: begin
                if (!(BLANK_LEADING && hun_q == 4'd0 &&
                      ten_q == 4'd0)) begin
                    an_nx  = 8'b11111101;
                    seg_nx = seg_of(ten_q);
                end
            end
            2'd2: begin
                if (!(BLANK_LEADING && hun_q == 4'd0)) begin
                    an_nx  = 8'b11111011;
                    seg_nx = seg_of(hun_q);
                end
            end
            default: begin
                an_nx  = 8'hFF;
                seg_nx = 8'hFF;
            end
        endcase
    end

    // Registered display outputs
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            An  <= 8'hFF;
            Seg <= 8'hFF;
        end else begin
            An  <= an_nx;
            Seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_snake_score_display.sv
// tb_snake_score_display: randomized and directed stimulus against a
// transaction-level reference model of the score display.
module tb_snake_score_display;

    localparam int RB = 6;
    localparam int PERIOD = 1 << RB;
    localparam int SLOT = 1 << (RB - 2);

    logic       CLK;
    logic       Reset;
    logic [7:0] Score;
    logic       Score_Valid;
    logic       Busy_b, Busy_z;
    logic [7:0] An_b, An_z;
    logic [7:0] Seg_b, Seg_z;

    int checks = 0;
    int failures = 0;

    // model state
    int  rc;
    int  disp;
    int  job;
    int  busy_cnt;
    int  pend;
    bit  pv;
    logic [7:0] ea_b, es_b, ea_z, es_z;

    // scan statistics
    int low_cnt [3];
    int dead_cnt;
    int multi_cnt;

    snake_score_display #(
        .REFRESH_BITS(RB),
        .BLANK_LEADING(1'b1)
    ) dut_b (
        .CLK(CLK),
        .Reset(Reset),
        .Score(Score),
        .Score_Valid(Score_Valid),
        .Busy(Busy_b),
        .An(An_b),
        .Seg(Seg_b)
    );

    snake_score_display #(
        .REFRESH_BITS(RB),
        .BLANK_LEADING(1'b0)
    ) dut_z (
        .CLK(CLK),
        .Reset(Reset),
        .Score(Score),
        .Score_Valid(Score_Valid),
        .Busy(Busy_z),
        .An(An_z),
        .Seg(Seg_z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        logic [7:0] s;
        case (d)
            0: s = 8'b00000011;
            1: s = 8'b10011111;
            2: s = 8'b00100101;
            3: s = 8'b00001101;
            4: s = 8'b10011001;
            5: s = 8'b01001001;
            6: s = 8'b01000001;
            7: s = 8'b00011111;
            8: s = 8'b00000001;
            9: s = 8'b00001001;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    task automatic render(input int ix, input int val, input bit blank,
                          output logic [7:0] an, output logic [7:0] sg);
        int h, t, u;
        h = val / 100;
        t = (val / 10) % 10;
        u = val % 10;
        an = 8'hFF;
        sg = 8'hFF;
        if (ix == 0) begin
            an = 8'b11111110;
            sg = seg_of(u);
        end else if (ix == 1) begin
            if (!(blank && h == 0 && t == 0)) begin
                an = 8'b11111101;
                sg = seg_of(t);
            end
        end else if (ix == 2) begin
            if (!(blank && h == 0)) begin
                an = 8'b11111011;
                sg = seg_of(h);
            end
        end
    endtask

    task automatic model_reset();
        rc = 0;
        disp = 0;
        job = 0;
        busy_cnt = 0;
        pend = 0;
        pv = 0;
        ea_b = 8'hFF;
        es_b = 8'hFF;
        ea_z = 8'hFF;
        es_z = 8'hFF;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) low_cnt[i] = 0;
        dead_cnt = 0;
        multi_cnt = 0;
    endtask

    // one clock: drive inputs, advance model, check at next negedge
    task automatic cyc(input bit sv, input logic [7:0] sc);
        int lows;
        Score_Valid = sv;
        Score = sc;
        render(rc / SLOT, disp, 1'b1, ea_b, es_b);
        render(rc / SLOT, disp, 1'b0, ea_z, es_z);
        rc = (rc + 1) % PERIOD;
        if (busy_cnt == 0) begin
            if (sv) begin
                job = sc;
                busy_cnt = 9;
            end
        end else begin
            if (sv) begin
                pend = sc;
                pv = 1;
            end
            busy_cnt--;
            if (busy_cnt == 0) begin
                disp = job;
                if (pv) begin
                    job = pend;
                    pv = 0;
                    busy_cnt = 9;
                end
            end
        end
        @(negedge CLK);
        check("busy_b", {31'd0, Busy_b}, {31'd0, busy_cnt > 0});
        check("busy_z", {31'd0, Busy_z}, {31'd0, busy_cnt > 0});
        check("an_b", {24'd0, An_b}, {24'd0, ea_b});
        check("seg_b", {24'd0, Seg_b}, {24'd0, es_b});
        check("an_z", {24'd0, An_z}, {24'd0, ea_z});
        check("seg_z", {24'd0, Seg_z}, {24'd0, es_z});
        lows = 0;
        for (int i = 0; i < 8; i++) if (An_z[i] == 1'b0) lows++;
        if (lows > 1) multi_cnt++;
        lows = 0;
        for (int i = 0; i < 8; i++) if (An_b[i] == 1'b0) lows++;
        if (lows > 1) multi_cnt++;
        for (int i = 0; i < 3; i++) if (An_z[i] == 1'b0) low_cnt[i]++;
        if (An_z == 8'hFF && Seg_z == 8'hFF) dead_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0);
    endtask

    // full refresh period: per-digit on-time and one-hot anodes
    task automatic scan_check();
        clear_stats();
        idle(PERIOD);
        check("an0_time", low_cnt[0], SLOT);
        check("an1_time", low_cnt[1], SLOT);
        check("an2_time", low_cnt[2], SLOT);
        check("dead_time", dead_cnt, SLOT);
        check("onehot_an", multi_cnt, 0);
    endtask

    task automatic do_reset(input int hold);
        Reset = 1'b0;
        Score_Valid = 1'b0;
        #1;
        check("rst_an_b", {24'd0, An_b}, 32'hFF);
        check("rst_seg_b", {24'd0, Seg_b}, 32'hFF);
        check("rst_an_z", {24'd0, An_z}, 32'hFF);
        check("rst_seg_z", {24'd0, Seg_z}, 32'hFF);
        check("rst_busy", {31'd0, Busy_b | Busy_z}, 32'd0);
        model_reset();
        repeat (hold) @(negedge CLK);
        Reset = 1'b1;
    endtask

    initial begin
        int vals [5];
        Reset = 1'b0;
        Score = 8'd0;
        Score_Valid = 1'b0;
        model_reset();
        clear_stats();
        repeat (2) @(negedge CLK);
        do_reset(2);

        // after release: "0" on units, upper digits blank
        cyc(1'b0, 8'd0);
        check("first_an_b", {24'd0, An_b}, 32'hFE);
        check("first_seg_b", {24'd0, Seg_b}, 32'h03);
        scan_check();

        // single conversion
        cyc(1'b1, 8'd237);
        idle(12);
        scan_check();

        // newest pending wins, 40 is dropped
        cyc(1'b1, 8'd5);
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd40);
        cyc(1'b1, 8'd99);
        idle(25);
        scan_check();

        // boundary values, both blanking modes
        vals = '{0, 9, 10, 100, 255};
        foreach (vals[i]) begin
            cyc(1'b1, 8'(vals[i]));
            idle(10);
            scan_check();
        end

        // reset mid-conversion
        cyc(1'b1, 8'd200);
        idle(4);
        @(negedge CLK);
        do_reset(2);
        cyc(1'b0, 8'd0);
        scan_check();

        // request arriving exactly in the commit cycle
        cyc(1'b1, 8'd17);
        idle(7);
        cyc(1'b1, 8'd88);
        idle(20);
        scan_check();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                @(negedge CLK);
                do_reset($urandom_range(1, 3));
            end else begin
                cyc($urandom_range(0, 5) == 0, 8'($urandom));
            end
        end
        scan_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_score_display.md
SNAKE_SCORE_DISPLAY -- requirements
Module: snake_score_display

Interface
REQ-001 Parameter REFRESH_BITS, default 17: width of the refresh counter; each digit is held for 2^(REFRESH_BITS-2) cycles.
REQ-002 Parameter BLANK_LEADING, default 1: 1 blanks leading zeros; 0 shows all three digits.
REQ-003 Port CLK, input, 1: the single clock; all state is on its rising edge.
REQ-004 Port Reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port Score, input, 8: unsigned snake length or score, 0..255.
REQ-006 Port Score_Valid, input, 1: one-cycle request to load Score.
REQ-007 Port Busy, output, 1: high while a conversion is in progress.
REQ-008 Port An, output, 8: anode enables, active-low, An[0] = rightmost digit.
REQ-009 Port Seg, output, 8: cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Function
REQ-010 States: IDLE, CONVERT, COMMIT; reset state IDLE.
REQ-011 IDLE with Score_Valid=1: capture Score into the shift register, clear the BCD accumulator and bit counter, go to CONVERT; Busy=1 from the next cycle.
REQ-012 CONVERT: one double-dabble step per cycle: add 3 to any BCD nibble >= 5, then shift left one bit; exactly 8 cycles, then go to COMMIT.
REQ-013 COMMIT: copy hundreds, tens and units into the displayed-digit registers in one cycle, all digits together; go to IDLE; Busy=0 in IDLE.
REQ-014 Latency: Score_Valid sampled at edge n -> new digits visible on Seg from edge n+10; Busy high for cycles n+1..n+9.
REQ-015 Score_Valid while Busy: store Score in a one-deep pending register; a later request overwrites it (newest wins).
REQ-016 In COMMIT with pending set: the next state is CONVERT loaded from the pending value and pending is cleared; Busy stays 1 with no gap.
REQ-017 Score_Valid in the same cycle as COMMIT: treated as a pending request, per REQ-016.
REQ-018 Displayed digits stay stable and are never partially updated during CONVERT.
REQ-019 The refresh counter is free-running (REFRESH_BITS bits) and wraps at all ones; the digit index is counter[REFRESH_BITS-1:REFRESH_BITS-2].
REQ-020 Digit index 0, 1, 2 drives An = 8'b11111110, 8'b11111101, 8'b11111011; index 3 drives An = 8'hFF and Seg = 8'hFF (dead slot).
REQ-021 An[7:3] are always 1.
REQ-022 Seg encoding, active-low {a..g,Dp}, Dp always 1:
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
REQ-023 With BLANK_LEADING=1: hundreds is blank (An bit held 1, Seg=FF) when it equals 0; tens is blank when hundreds=0 and tens=0; units is never blank.
REQ-024 An and Seg are registered outputs, one cycle after the index and digit that produce them; there is no combinational path from Score to the outputs.
REQ-025 Score is fixed at 8 bits, so hundreds <= 2 and no overflow can occur; BCD nibbles are 4 bits each.

Reset
REQ-026 While Reset=0: state=IDLE, Busy=0, pending cleared, displayed digits=0, refresh counter=0, An=8'hFF, Seg=8'hFF.
REQ-027 Reset asserted mid-CONVERT or mid-COMMIT: abort; displayed digits return to 0; no partial value is ever shown.
REQ-028 After Reset rises: the first scan of index 0 shows "0" (Seg=00000011 on An[0]).

Verification
REQ-029 Reset release, no Score_Valid -> An[0] low with Seg=00000011; An[1], An[2] stay high (blanked); Busy=0.
REQ-030 Score=237 pulse at edge n -> Busy=1 for n+1..n+9; index 2/1/0 show 2/3/7 (00100101, 00001101, 00011111) from n+10.
REQ-031 Score=5, then Score=40 two cycles later, then Score=99 one cycle after that -> 5 is displayed, then 99 with no gap in Busy; 40 is never displayed.
REQ-032 Score=0, 9, 10, 100, 255 with BLANK_LEADING=1 -> digit patterns "  0", "  9", " 10", "100", "255"; with BLANK_LEADING=0 -> "000", "009", "010", "100", "255".
REQ-033 Reset pulled low 4 cycles into converting 200 -> An=FF and Seg=FF at once; after release, "0" is displayed.
REQ-034 Run 2^REFRESH_BITS cycles -> each of An[0..2] is low for exactly 2^(REFRESH_BITS-2) cycles and the index-3 slot is all high; never more than one An bit is low.
